sp_ram_rr_arbiter: RTL

//   Shares one SyncSpRamBeNx64 instance among NUM_PORTS requesters using a req/gnt/rvalid handshake.

---
 rtl/sp_ram_rr_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/sp_ram_rr_arbiter.sv
// rtl/sp_ram_rr_arbiter.sv - round-robin req/gnt/rvalid arbiter sharing one single-port 64-bit RAM
module sp_ram_rr_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 10,
    parameter int OUT_REGS   = 0
) (
    input  logic                            Clk_CI,
    input  logic                            Rst_RI,
    input  logic [NUM_PORTS-1:0]            Req_SI,
    input  logic [NUM_PORTS-1:0]            WrEn_SI,
    input  logic [NUM_PORTS*8-1:0]          BEn_SI,
    input  logic [NUM_PORTS*64-1:0]         WrData_DI,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] Addr_DI,
    output logic [NUM_PORTS-1:0]            Gnt_SO,
    output logic [NUM_PORTS-1:0]            RValid_SO,
    output logic [63:0]                     RdData_DO,
    output logic                            RamCSel_SO,
    output logic                            RamWrEn_SO,
    output logic [7:0]                      RamBEn_SO,
    output logic [63:0]                     RamWrData_DO,
    output logic [ADDR_WIDTH-1:0]           RamAddr_DO,
    input  logic [63:0]                     RamRdData_DI
);

    localparam int RL    = 1 + OUT_REGS;
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef logic [IDX_W-1:0] idx_t;

    idx_t            ptr_q, ptr_d;
    idx_t            win_idx;
    idx_t            cand;
    logic            win_found;
    logic            grant_vld;

    logic [RL-1:0]   vld_q, vld_d;
    idx_t [RL-1:0]   idx_q, idx_d;

    // Search upward from the pointer with wrap-around; the first requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = idx_t'((int'(ptr_q) + i) % NUM_PORTS);
            if (!win_found && Req_SI[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Nothing is granted while reset is held, so the RAM never sees a stray access.
    assign grant_vld = win_found & ~Rst_RI;

    // One-hot grant and RAM-side mux from the winning port.
    always_comb begin
        Gnt_SO       = '0;
        RamWrEn_SO   = 1'b0;
        RamBEn_SO    = '0;
        RamWrData_DO = '0;
        RamAddr_DO   = '0;
        if (grant_vld) begin
            Gnt_SO[win_idx] = 1'b1;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (idx_t'(i) == win_idx) begin
                RamWrEn_SO   = grant_vld & WrEn_SI[i];
                RamBEn_SO    = BEn_SI[i*8 +: 8];
                RamWrData_DO = WrData_DI[i*64 +: 64];
                RamAddr_DO   = Addr_DI[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign RamCSel_SO = grant_vld;
    assign RdData_DO  = RamRdData_DI;

    // Pointer moves to just past the winner; pipeline shifts in the new grant each cycle.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = (win_idx == idx_t'(NUM_PORTS - 1)) ? '0 : win_idx + idx_t'(1);
        end
        vld_d    = '0;
        idx_d    = '0;
        vld_d[0] = grant_vld;
        idx_d[0] = win_idx;
        for (int k = 1; k < RL; k++) begin
            vld_d[k] = vld_q[k-1];
            idx_d[k] = idx_q[k-1];
        end
    end

    // State registers; reset discards any in-flight responses.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            ptr_q <= '0;
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            vld_q <= vld_d;
            idx_q <= idx_d;
        end
    end

    // Response valid decoded from the last pipeline stage, aligned with RAM read data.
    always_comb begin
        RValid_SO = '0;
        if (vld_q[RL-1] && !Rst_RI) begin
            RValid_SO[idx_q[RL-1]] = 1'b1;
        end
    end

    cfg_num_ports: assert property (@(posedge Clk_CI) (NUM_PORTS >= 2 && NUM_PORTS <= 8));
    gnt_onehot:    assert property (@(posedge Clk_CI) disable iff (Rst_RI) $onehot0(Gnt_SO));
    rvalid_onehot: assert property (@(posedge Clk_CI) disable iff (Rst_RI) $onehot0(RValid_SO));

endmodule
